// File: rtl/adc16dv160_input_common.sv
// ---------------------------------------------------------------------------
// adc16dv160_input_common
// Shared definitions for the ADC16DV160 input capture path.
//   SAMPLE_W        : ADC sample width
//   DATA_W          : stream word width (two samples)
//   TEST_RAMP_INIT  : start value of the internal test ramp
//   capture_state_t : frame capture FSM states
// ---------------------------------------------------------------------------
package adc16dv160_input_common;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned DATA_W   = 32;

   localparam logic [SAMPLE_W-1:0] TEST_RAMP_INIT = 16'h0000;

   typedef enum logic [1:0] {
      CAP_IDLE,
      CAP_RUN,
      CAP_DRAIN
   } capture_state_t;

endpackage

// File: rtl/adc16dv160_input_pack.sv
// ---------------------------------------------------------------------------
// adc16dv160_input_pack
// Two-sample packer with internal test ramp.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   sample        : ADC sample
//   valid         : sample strobe
//   test          : 1 = ramp value replaces sample (sampled per strobe)
//   clear         : synchronous clear of ramp and half-word flag
//   word          : {second sample, first sample}, valid with word_valid
//   word_valid    : combinational; high on the strobe completing a word
// ---------------------------------------------------------------------------
module adc16dv160_input_pack #(
   parameter int unsigned SAMPLE_W = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [SAMPLE_W-1:0]   sample,
   input  logic                  valid,
   input  logic                  test,
   input  logic                  clear,
   output logic [2*SAMPLE_W-1:0] word,
   output logic                  word_valid
);

   import adc16dv160_input_common::*;

   logic [SAMPLE_W-1:0] ramp;
   logic [SAMPLE_W-1:0] lo;
   logic [SAMPLE_W-1:0] cur;
   logic                half;

   always_comb begin
      cur = test ? ramp : sample;
   end

   // The second sample is presented straight through so the consumer can
   // register the word on the same edge that accepts the second strobe.
   assign word       = {cur, lo};
   assign word_valid = valid & half & ~clear;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ramp <= TEST_RAMP_INIT;
         lo   <= '0;
         half <= 1'b0;
      end else if (clear) begin
         ramp <= TEST_RAMP_INIT;
         half <= 1'b0;
      end else if (valid) begin
         if (test) begin
            ramp <= ramp + SAMPLE_W'(1);
         end
         if (!half) begin
            lo <= cur;
         end
         half <= ~half;
      end
   end

endmodule

// File: rtl/adc16dv160_input_capture.sv
// ---------------------------------------------------------------------------
// adc16dv160_input_capture
// Frame capture stage: packs ADC samples (or a test ramp) into 32-bit words
// and emits frames of exactly dsize words on an AXI4-Stream master.
//   ACLK, ARESETN   : clock, asynchronous active-low reset
//   dsize           : frame length in words (0 = no frame)
//   cr_start        : single-cycle start pulse (ignored while busy)
//   cr_test         : 1 = internal ramp replaces adc_data
//   cr_rt           : 1 = restart a frame after each TLAST
//   adc_data/valid  : ADC sample and strobe
//   M_AXIS_*        : stream master, single-entry output register
//   busy            : high outside IDLE
//   overflow        : sticky, a completed word was dropped by backpressure
// ---------------------------------------------------------------------------
module adc16dv160_input_capture #(
   parameter int unsigned SAMPLE_W = 16,
   parameter int unsigned DATA_W   = 32
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic [31:0]         dsize,
   input  logic                cr_start,
   input  logic                cr_test,
   input  logic                cr_rt,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   output logic [DATA_W-1:0]   M_AXIS_TDATA,
   output logic                M_AXIS_TVALID,
   input  logic                M_AXIS_TREADY,
   output logic                M_AXIS_TLAST,
   output logic                busy,
   output logic                overflow
);

   import adc16dv160_input_common::*;

   capture_state_t      state;
   logic [31:0]         frame_len;
   logic [31:0]         word_cnt;
   logic [DATA_W-1:0]   word;
   logic                word_valid;
   logic                pack_valid;
   logic                pack_clear;
   logic                accept;
   logic                last_word;

   // Samples only count while capturing; the packer is held cleared in
   // IDLE and DRAIN so every frame restarts from ramp 0 and an empty half.
   assign pack_valid = adc_valid & (state == CAP_RUN);
   assign pack_clear = (state != CAP_RUN);
   assign accept     = M_AXIS_TVALID & M_AXIS_TREADY;
   assign last_word  = (word_cnt == frame_len - 32'd1);
   assign busy       = (state != CAP_IDLE);

   adc16dv160_input_pack #(
      .SAMPLE_W (SAMPLE_W)
   ) u_pack (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .sample     (adc_data),
      .valid      (pack_valid),
      .test       (cr_test),
      .clear      (pack_clear),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state         <= CAP_IDLE;
         frame_len     <= '0;
         word_cnt      <= '0;
         M_AXIS_TDATA  <= '0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TLAST  <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         case (state)
            CAP_IDLE: begin
               if (cr_start && (dsize != '0)) begin
                  state     <= CAP_RUN;
                  frame_len <= dsize;
                  word_cnt  <= '0;
                  overflow  <= 1'b0;
               end
            end

            CAP_RUN: begin
               if (word_valid) begin
                  // Register still occupied and not leaving this cycle:
                  // drop the word without advancing the count.
                  if (M_AXIS_TVALID && !M_AXIS_TREADY) begin
                     overflow <= 1'b1;
                  end else begin
                     M_AXIS_TDATA  <= word;
                     M_AXIS_TVALID <= 1'b1;
                     M_AXIS_TLAST  <= last_word;
                     word_cnt      <= word_cnt + 32'd1;
                     if (last_word) begin
                        state <= CAP_DRAIN;
                     end
                  end
               end else if (accept) begin
                  M_AXIS_TVALID <= 1'b0;
                  M_AXIS_TLAST  <= 1'b0;
               end
            end

            CAP_DRAIN: begin
               if (accept && M_AXIS_TLAST) begin
                  M_AXIS_TVALID <= 1'b0;
                  M_AXIS_TLAST  <= 1'b0;
                  if (cr_rt && (dsize != '0)) begin
                     state     <= CAP_RUN;
                     frame_len <= dsize;
                     word_cnt  <= '0;
                  end else begin
                     state <= CAP_IDLE;
                  end
               end
            end

            default: state <= CAP_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc16dv160_input_capture.sv
module tb_adc16dv160_input_capture;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic [31:0] dsize = '0;
   logic        cr_start = 1'b0;
   logic        cr_test = 1'b0;
   logic        cr_rt = 1'b0;
   logic [15:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [31:0] M_AXIS_TDATA;
   logic        M_AXIS_TVALID;
   logic        M_AXIS_TREADY = 1'b0;
   logic        M_AXIS_TLAST;
   logic        busy;
   logic        overflow;

   adc16dv160_input_capture #(
      .SAMPLE_W (16),
      .DATA_W   (32)
   ) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .dsize         (dsize),
      .cr_start      (cr_start),
      .cr_test       (cr_test),
      .cr_rt         (cr_rt),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .busy          (busy),
      .overflow      (overflow)
   );

   always #5 ACLK = ~ACLK;

   int unsigned n_checks = 0;
   int unsigned n_err = 0;
   logic [32:0] got[$];   // {tlast, tdata} of every handshake

   // Reference model state (frame-level rules, evaluated per clock)
   bit          use_model = 0;
   logic        m_busy, m_drain, m_half, m_v, m_l, m_ovf;
   logic [15:0] m_ramp, m_lo;
   logic [31:0] m_len, m_cnt, m_d;

   typedef struct {
      logic [31:0] dsize;
      logic        test;
      int unsigned stall;
      int unsigned nvalid;
      logic [15:0] d0;
      logic [15:0] d1;
      int unsigned n_words;
      logic [31:0] first;
      logic [31:0] last;
      logic        ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_busy = 0; m_drain = 0; m_half = 0; m_v = 0; m_l = 0; m_ovf = 0;
      m_ramp = '0; m_lo = '0; m_len = '0; m_cnt = '0; m_d = '0;
   endtask

   task automatic model_step(input logic st, input logic v, input logic [15:0] d, input logic rdy);
      logic        acc;
      logic [15:0] s;
      acc = m_v && rdy;
      if (!m_busy) begin
         if (st && dsize != 0) begin
            m_busy = 1; m_len = dsize; m_cnt = 0; m_ramp = 0; m_half = 0; m_ovf = 0;
         end
      end else if (!m_drain) begin
         if (acc) begin m_v = 0; m_l = 0; end
         if (v) begin
            s = cr_test ? m_ramp : d;
            if (cr_test) m_ramp = m_ramp + 16'd1;
            if (!m_half) begin
               m_lo = s; m_half = 1;
            end else begin
               m_half = 0;
               if (m_v) m_ovf = 1;
               else begin
                  m_v = 1; m_d = {s, m_lo}; m_l = (m_cnt == m_len - 1);
                  m_cnt = m_cnt + 1; m_drain = m_l;
               end
            end
         end
      end else if (acc) begin
         m_v = 0; m_l = 0; m_drain = 0;
         if (cr_rt && dsize != 0) begin
            m_len = dsize; m_cnt = 0; m_ramp = 0; m_half = 0;
         end else m_busy = 0;
      end
   endtask

   // One clock: drive inputs, log handshake, advance, check hold and model.
   task automatic cyc(input logic v, input logic [15:0] d, input logic rdy, input logic st);
      logic        hold;
      logic [31:0] hd;
      logic        hl;
      adc_valid = v; adc_data = d; M_AXIS_TREADY = rdy; cr_start = st;
      if (M_AXIS_TVALID && rdy) got.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      hold = M_AXIS_TVALID && !rdy;
      hd = M_AXIS_TDATA; hl = M_AXIS_TLAST;
      if (use_model) model_step(st, v, d, rdy);
      @(posedge ACLK); #1;
      cr_start = 0; adc_valid = 0;
      if (hold) begin
         chk("hold_tvalid", M_AXIS_TVALID, 1'b1);
         chk("hold_tdata", M_AXIS_TDATA, hd);
         chk("hold_tlast", M_AXIS_TLAST, hl);
      end
      if (use_model) begin
         chk("m_tvalid", M_AXIS_TVALID, m_v);
         chk("m_tlast", M_AXIS_TLAST, m_l);
         chk("m_busy", busy, m_busy);
         chk("m_overflow", overflow, m_ovf);
         if (m_v) chk("m_tdata", M_AXIS_TDATA, m_d);
      end
   endtask

   task automatic wait_idle(input string name);
      int unsigned n = 0;
      while (busy && n < 60) begin
         cyc(0, '0, 1, 0);
         n++;
      end
      chk(name, busy, 1'b0);
   endtask

   task automatic run_vec(input vec_t e);
      got.delete();
      dsize = e.dsize; cr_test = e.test; cr_rt = 0;
      cyc(0, '0, 1, 1);
      for (int unsigned k = 0; k < e.nvalid; k++)
         cyc(1, k[0] ? e.d1 : e.d0, k >= e.stall, 0);
      wait_idle("vec_idle");
      chk("vec_nwords", got.size(), e.n_words);
      if (got.size() == e.n_words && e.n_words > 0) begin
         chk("vec_first", got[0][31:0], e.first);
         chk("vec_last", got[e.n_words-1][31:0], e.last);
         for (int unsigned i = 0; i < e.n_words; i++)
            chk("vec_tlast", got[i][32], i == e.n_words - 1);
      end
      chk("vec_overflow", overflow, e.ovf);
   endtask

   initial begin
      int unsigned n;
      model_clear();
      vecs[0] = '{32'd4, 1'b1, 0,  8,  16'h0000, 16'h0000, 4, 32'h00010000, 32'h00070006, 1'b0};
      vecs[1] = '{32'd3, 1'b1, 10, 14, 16'h0000, 16'h0000, 3, 32'h00010000, 32'h000D000C, 1'b1};
      vecs[2] = '{32'd1, 1'b0, 0,  2,  16'h1234, 16'hABCD, 1, 32'hABCD1234, 32'hABCD1234, 1'b0};
      vecs[3] = '{32'd2, 1'b0, 0,  4,  16'hFFFF, 16'h0000, 2, 32'h0000FFFF, 32'h0000FFFF, 1'b0};
      vecs[4] = '{32'd1, 1'b1, 3,  2,  16'h0000, 16'h0000, 1, 32'h00010000, 32'h00010000, 1'b0};

      // Reset values
      repeat (2) @(posedge ACLK);
      #1;
      chk("rst_tvalid", M_AXIS_TVALID, 1'b0);
      chk("rst_tlast", M_AXIS_TLAST, 1'b0);
      chk("rst_tdata", M_AXIS_TDATA, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      ARESETN = 1;
      cyc(0, '0, 1, 0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // ADC path latency: word visible right after the second strobe
      got.delete(); dsize = 1; cr_test = 0;
      cyc(0, '0, 0, 1);
      cyc(1, 16'h1234, 0, 0);
      chk("lat_tvalid_early", M_AXIS_TVALID, 1'b0);
      cyc(1, 16'hABCD, 0, 0);
      chk("lat_tvalid", M_AXIS_TVALID, 1'b1);
      chk("lat_tdata", M_AXIS_TDATA, 32'hABCD1234);
      chk("lat_tlast", M_AXIS_TLAST, 1'b1);
      cyc(0, '0, 0, 0);
      wait_idle("lat_idle");
      chk("lat_nwords", got.size(), 1);

      // dsize = 0 start is ignored
      dsize = 0; cr_test = 1;
      cyc(0, '0, 1, 1);
      cyc(1, '0, 1, 0);
      cyc(1, '0, 1, 0);
      chk("zero_busy", busy, 1'b0);
      chk("zero_tvalid", M_AXIS_TVALID, 1'b0);

      // Start while busy has no effect
      got.delete(); dsize = 2;
      cyc(0, '0, 1, 1);
      cyc(1, '0, 1, 0);
      dsize = 5;
      cyc(0, '0, 1, 1);
      cyc(1, '0, 1, 0);
      cyc(1, '0, 1, 0);
      cyc(1, '0, 1, 0);
      wait_idle("sb_idle");
      chk("sb_nwords", got.size(), 2);
      if (got.size() == 2) begin
         chk("sb_w0", got[0][31:0], 32'h00010000);
         chk("sb_w1", got[1][31:0], 32'h00030002);
         chk("sb_tlast", got[1][32], 1'b1);
      end

      // Continuous mode, then drop cr_rt mid-frame
      got.delete(); dsize = 2; cr_test = 1; cr_rt = 1;
      cyc(0, '0, 1, 1);
      for (int i = 0; i < 100 && got.size() < 5; i++) cyc(1, '0, 1, 0);
      cr_rt = 0;
      n = 0;
      while (busy && n < 50) begin cyc(1, '0, 1, 0); n++; end
      chk("rt_idle", busy, 1'b0);
      chk("rt_nwords", got.size(), 6);
      for (int i = 0; i < got.size(); i++) begin
         chk("rt_data", got[i][31:0], i[0] ? 32'h00030002 : 32'h00010000);
         chk("rt_tlast", got[i][32], i[0]);
      end

      // Asynchronous reset mid-frame (max dsize, with a drop pending)
      dsize = 32'hFFFFFFFF; cr_test = 1;
      cyc(0, '0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, '0, 0, 0);
      chk("big_tvalid", M_AXIS_TVALID, 1'b1);
      chk("big_tlast", M_AXIS_TLAST, 1'b0);
      chk("big_overflow", overflow, 1'b1);
      #2 ARESETN = 0;
      #1;
      chk("ar_tvalid", M_AXIS_TVALID, 1'b0);
      chk("ar_tlast", M_AXIS_TLAST, 1'b0);
      chk("ar_tdata", M_AXIS_TDATA, 32'h0);
      chk("ar_busy", busy, 1'b0);
      chk("ar_overflow", overflow, 1'b0);
      @(negedge ACLK) ARESETN = 1;
      @(posedge ACLK); #1;
      got.delete(); dsize = 1;
      cyc(0, '0, 1, 1);
      cyc(1, '0, 1, 0);
      cyc(1, '0, 1, 0);
      wait_idle("ar_idle");
      chk("ar_nwords", got.size(), 1);
      if (got.size() == 1) begin
         chk("ar_w0", got[0][31:0], 32'h00010000);
         chk("ar_w0_tlast", got[0][32], 1'b1);
      end

      // Randomized frames against the reference model
      ARESETN = 0; #10; ARESETN = 1;
      model_clear();
      use_model = 1;
      for (int f = 0; f < 8; f++) begin
         dsize = $urandom_range(1, 6);
         cr_test = 1'($urandom_range(0, 1));
         cyc(0, '0, 1'($urandom_range(0, 1)), 1);
         n = 0;
         while (m_busy && n < 300) begin
            cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
            n++;
         end
         chk("rand_done", m_busy, 1'b0);
      end
      use_model = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
